// File: rtl/packet_scheduler_pkg.sv
// Shared constants and types for the TS packet scheduler.
// Register map offsets, FSM encodings and source counts.
package packet_scheduler_pkg;

    localparam int N_SRC        = 4;
    localparam int WGT_W        = 4;
    localparam int NULL_TIMEOUT = 1024;
    localparam int TS_PKT_LEN   = 188;

    localparam logic [7:0] ADDR_SCHED_BASE = 8'h40;
    localparam logic [7:0] REG_WGT0        = 8'd0;
    localparam logic [7:0] REG_MODE        = 8'd4;
    localparam logic [7:0] REG_ERR_CLR     = 8'd5;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    typedef logic [WGT_W-1:0] wgt_t;

endpackage

// File: rtl/packet_scheduler_if.sv
// Grant handshake and SPI register bus between scheduler and mux.
// master = scheduler side, slave = mux / SPI side.
interface packet_scheduler_if;
    import packet_scheduler_pkg::*;

    logic [7:0] SPI_ADDRESS;
    logic [7:0] SPI_DATA;
    logic       RISING_SS;
    logic       GRANT_READY;
    logic       PKT_DONE;
    logic       GRANT_VALID;
    logic [1:0] GRANT_SRC;
    logic       GRANT_NULL;

    modport master (
        input  SPI_ADDRESS, SPI_DATA, RISING_SS,
        input  GRANT_READY, PKT_DONE,
        output GRANT_VALID, GRANT_SRC, GRANT_NULL
    );

    modport slave (
        output SPI_ADDRESS, SPI_DATA, RISING_SS,
        output GRANT_READY, PKT_DONE,
        input  GRANT_VALID, GRANT_SRC, GRANT_NULL
    );

endinterface

// File: rtl/packet_scheduler_rr_pick4.sv
// Cyclic first-one finder over 4 requests starting at a pointer.
// Lowest distance from the pointer wins.
module rr_pick4
    import packet_scheduler_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic             found_o,
    output logic [1:0]       idx_o
);

    logic [1:0] cand;

    // Walk farthest-first so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = ptr_i + 2'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// WRR / strict-priority grant scheduler for the TS packet mux.
// One grant per packet slot; null slot after an idle timeout.
module packet_scheduler
    import packet_scheduler_pkg::*;
#(
    parameter int TIMEOUT = NULL_TIMEOUT
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic [N_SRC-1:0]  GOT_FULL_PACKET,
    packet_scheduler_if.master bus,
    output logic              ERR_PROTO,
    output logic [1:0]        state_mon
);

    localparam int IW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    wgt_t          wgt_q [N_SRC];
    wgt_t          wgt_d [N_SRC];
    wgt_t          credit_q [N_SRC];
    wgt_t          credit_d [N_SRC];
    logic          mode_q, mode_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          gv_q, gv_d;
    logic [1:0]    gs_q, gs_d;
    logic          gn_q, gn_d;
    logic          err_q, err_d;

    logic [N_SRC-1:0] elig, req;
    logic [1:0]       pick_ptr, pick_idx;
    logic             pick_hit;
    logic [7:0]       reg_off;
    logic             spi_unused;

    always_comb begin
        elig = '0;
        req  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            elig[i] = GOT_FULL_PACKET[i] && (wgt_q[i] != '0);
            req[i]  = mode_q ? elig[i]
                             : (elig[i] && (credit_q[i] != '0));
        end
    end

    assign pick_ptr = mode_q ? 2'd0 : ptr_q;

    rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .found_o (pick_hit),
        .idx_o   (pick_idx)
    );

    assign reg_off    = bus.SPI_ADDRESS - ADDR_SCHED_BASE;
    assign spi_unused = ^bus.SPI_DATA;

    always_comb begin
        state_d  = state_q;
        wgt_d    = wgt_q;
        credit_d = credit_q;
        mode_d   = mode_q;
        ptr_d    = ptr_q;
        idle_d   = idle_q;
        gv_d     = gv_q;
        gs_d     = gs_q;
        gn_d     = gn_q;
        err_d    = err_q;

        if (bus.RISING_SS) begin
            if (reg_off < REG_MODE)
                wgt_d[reg_off[1:0]] = bus.SPI_DATA[WGT_W-1:0];
            else if (reg_off == REG_MODE)
                mode_d = bus.SPI_DATA[0];
            else if (reg_off == REG_ERR_CLR && bus.SPI_DATA[0])
                err_d = 1'b0;
        end

        unique case (state_q)
            ST_ARB: begin
                if (bus.PKT_DONE)
                    err_d = 1'b1;
                if (pick_hit) begin
                    gv_d    = 1'b1;
                    gs_d    = pick_idx;
                    gn_d    = 1'b0;
                    idle_d  = '0;
                    state_d = ST_OFFER;
                    if (!mode_q) begin
                        credit_d[pick_idx] =
                            credit_q[pick_idx] - wgt_t'(1);
                        // Stay on the winner until its burst is spent.
                        if (credit_q[pick_idx] == wgt_t'(1))
                            ptr_d = pick_idx + 2'd1;
                        else
                            ptr_d = pick_idx;
                    end
                end else if (|elig) begin
                    credit_d = wgt_q;
                end else if (idle_q == IDLE_LAST) begin
                    gv_d    = 1'b1;
                    gn_d    = 1'b1;
                    idle_d  = '0;
                    state_d = ST_OFFER;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_OFFER: begin
                if (bus.PKT_DONE)
                    err_d = 1'b1;
                if (gv_q && bus.GRANT_READY) begin
                    gv_d    = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.PKT_DONE) begin
                    gn_d    = 1'b0;
                    state_d = ST_ARB;
                end
            end
            default: begin
                gv_d    = 1'b0;
                gn_d    = 1'b0;
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q <= ST_ARB;
            for (int i = 0; i < N_SRC; i++) begin
                wgt_q[i]    <= wgt_t'(1);
                credit_q[i] <= wgt_t'(1);
            end
            mode_q <= 1'b0;
            ptr_q  <= '0;
            idle_q <= '0;
            gv_q   <= 1'b0;
            gs_q   <= '0;
            gn_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wgt_q    <= wgt_d;
            credit_q <= credit_d;
            mode_q   <= mode_d;
            ptr_q    <= ptr_d;
            idle_q   <= idle_d;
            gv_q     <= gv_d;
            gs_q     <= gs_d;
            gn_q     <= gn_d;
            err_q    <= err_d;
        end
    end

    assign bus.GRANT_VALID = gv_q;
    assign bus.GRANT_SRC   = gs_q;
    assign bus.GRANT_NULL  = gn_q;
    assign ERR_PROTO       = err_q;
    assign state_mon       = state_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: WRR, weights, strict mode,
// null timeout, READY backpressure, protocol error and reset.
module tb_packet_scheduler;
    import packet_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] got;
    logic       err;
    logic [1:0] st;
    int         checks = 0;
    int         errors = 0;

    packet_scheduler_if bus ();

    packet_scheduler dut (
        .SYS_CLK         (clk),
        .RST             (rst),
        .GOT_FULL_PACKET (got),
        .bus             (bus),
        .ERR_PROTO       (err),
        .state_mon       (st)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic spi_wr(input logic [7:0] a, input logic [7:0] d);
        bus.SPI_ADDRESS = a;
        bus.SPI_DATA    = d;
        bus.RISING_SS   = 1'b1;
        tick;
        bus.RISING_SS   = 1'b0;
    endtask

    task automatic wait_grant(input string tag,
                              input int exp_src,
                              input logic exp_null);
        int n = 0;
        while (bus.GRANT_VALID !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, bus.GRANT_VALID, 1);
        if (!exp_null)
            check({tag, "_src"}, bus.GRANT_SRC, exp_src);
        check({tag, "_null"}, bus.GRANT_NULL, exp_null);
        tick;
        check({tag, "_acc"}, st, ST_BUSY);
    endtask

    task automatic finish_pkt;
        repeat (10) tick;
        bus.PKT_DONE = 1'b1;
        tick;
        bus.PKT_DONE = 1'b0;
    endtask

    int seq1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq2 [9] = '{0, 0, 0, 1, 3, 3, 0, 0, 0};

    initial begin
        rst             = 1'b1;
        got             = 4'b0000;
        bus.SPI_ADDRESS = 8'h00;
        bus.SPI_DATA    = 8'h00;
        bus.RISING_SS   = 1'b0;
        bus.GRANT_READY = 1'b0;
        bus.PKT_DONE    = 1'b0;
        tick;
        tick;
        check("rst_valid", bus.GRANT_VALID, 0);
        check("rst_src", bus.GRANT_SRC, 0);
        check("rst_null", bus.GRANT_NULL, 0);
        check("rst_err", err, 0);
        check("rst_state", st, ST_ARB);
        rst = 1'b0;

        // Equal weights: plain round robin.
        got             = 4'b1111;
        bus.GRANT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_grant($sformatf("wrr1_%0d", i), seq1[i], 1'b0);
            if (i == 7) begin
                spi_wr(8'h40, 8'd3);
                spi_wr(8'h41, 8'd1);
                spi_wr(8'h42, 8'd0);
                spi_wr(8'h43, 8'd2);
            end
            finish_pkt;
        end

        // Weights {3,1,0,2}: bursts, source 2 disabled.
        for (int i = 0; i < 9; i++) begin
            wait_grant($sformatf("wrr2_%0d", i), seq2[i], 1'b0);
            if (i == 8) begin
                spi_wr(8'h44, 8'd1);
                got = 4'b1010;
            end
            finish_pkt;
        end

        // Strict priority.
        wait_grant("sp0", 1, 1'b0);
        finish_pkt;
        wait_grant("sp1", 1, 1'b0);
        got = 4'b1000;
        finish_pkt;
        wait_grant("sp2", 3, 1'b0);
        got = 4'b0000;
        finish_pkt;

        // Null grant exactly at the timeout.
        repeat (1023) tick;
        check("null_early", bus.GRANT_VALID, 0);
        tick;
        check("null_valid", bus.GRANT_VALID, 1);
        check("null_flag", bus.GRANT_NULL, 1);
        check("null_state", st, ST_OFFER);
        tick;
        check("null_acc", st, ST_BUSY);
        finish_pkt;
        check("null_clr", bus.GRANT_NULL, 0);

        // Request one cycle before timeout wins over null.
        repeat (1023) tick;
        check("late_idle", bus.GRANT_VALID, 0);
        got = 4'b0010;
        tick;
        check("late_valid", bus.GRANT_VALID, 1);
        check("late_null", bus.GRANT_NULL, 0);
        check("late_src", bus.GRANT_SRC, 1);

        // Backpressure: grant held while READY is low.
        bus.GRANT_READY = 1'b0;
        got = 4'b0000;
        for (int i = 0; i < 50; i++) begin
            tick;
            check($sformatf("hold_v%0d", i), bus.GRANT_VALID, 1);
            check($sformatf("hold_s%0d", i), bus.GRANT_SRC, 1);
        end
        check("hold_state", st, ST_OFFER);
        bus.GRANT_READY = 1'b1;
        tick;
        check("hold_acc_v", bus.GRANT_VALID, 0);
        check("hold_acc_st", st, ST_BUSY);

        // Reset while busy.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst2_valid", bus.GRANT_VALID, 0);
        check("rst2_src", bus.GRANT_SRC, 0);
        check("rst2_null", bus.GRANT_NULL, 0);
        check("rst2_state", st, ST_ARB);

        // Stray PKT_DONE in ARB.
        bus.PKT_DONE = 1'b1;
        tick;
        bus.PKT_DONE = 1'b0;
        check("perr_set", err, 1);
        check("perr_state", st, ST_ARB);
        tick;
        check("perr_sticky", err, 1);
        spi_wr(8'h45, 8'd1);
        check("perr_clr", err, 0);

        // Weights back to 1 after reset: source 2 served.
        got = 4'b0100;
        wait_grant("rst_wgt", 2, 1'b0);
        got = 4'b0000;
        finish_pkt;
        check("end_state", st, ST_ARB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
